// File: rtl/player_mover_pkg.sv
// Shared cell/direction codes and state encodings for the arena player-move engine.
package player_mover_pkg;

  typedef enum logic [2:0] {
    CELL_TILE   = 3'd0,
    CELL_PLAYER = 3'd1,
    CELL_WALL   = 3'd2,
    CELL_BLOCK  = 3'd3,
    CELL_BOMB   = 3'd4
  } cell_t;

  localparam logic [2:0] DIR_IDLE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_DOWN  = 3'd3;
  localparam logic [2:0] DIR_LEFT  = 3'd4;
  localparam logic [2:0] DIR_PLANT = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_RD_CAP,
    S_DECIDE,
    S_WR_OLD,
    S_PLOT_OLD,
    S_MOVE,
    S_WR_NEW,
    S_PLOT_NEW
  } state_t;

  // Scan order of the neighbour cells.
  typedef enum logic [1:0] {
    NB_LEFT,
    NB_RIGHT,
    NB_UP,
    NB_DOWN
  } nb_t;

endpackage

// File: rtl/player_mover_if.sv
// Plot request channel towards the VGA plotter (valid/ready).
interface player_mover_if #(
  parameter int unsigned CW = 4
);
  logic          plot;
  logic          plot_ready;
  logic [CW-1:0] plot_x;
  logic [CW-1:0] plot_y;
  logic [2:0]    plot_val;

  modport master (output plot, plot_x, plot_y, plot_val, input plot_ready);
  modport slave  (input plot, plot_x, plot_y, plot_val, output plot_ready);
endinterface

// File: rtl/player_mover_ram_read_timer.sv
// Counts out the extra wait cycles of a RAM read after the address cycle.
module ram_read_timer #(
  parameter int unsigned LAT = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  output logic done
);
  localparam int unsigned W = (LAT > 1) ? $clog2(LAT) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(LAT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // done marks the final wait cycle, so capture follows immediately after.
  assign done = (cnt <= W'(1));

endmodule

// File: rtl/player_mover.sv
// Player-move engine: scans the four neighbours from arena RAM, moves/plants, and redraws.
module player_mover
  import player_mover_pkg::*;
#(
  parameter int unsigned CW      = 4,
  parameter int unsigned MAX_X   = 11,
  parameter int unsigned MAX_Y   = 9,
  parameter int unsigned RAM_LAT = 2,
  parameter int unsigned SPAWN_X = 1,
  parameter int unsigned SPAWN_Y = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ld,
  input  logic [2:0]            dir,
  input  logic [2:0]            ram_rdata,
  output logic [CW-1:0]         ram_x,
  output logic [CW-1:0]         ram_y,
  output logic                  ram_wren,
  output logic [2:0]            ram_wdata,
  output logic [2:0]            up_r,
  output logic [2:0]            right_r,
  output logic [2:0]            down_r,
  output logic [2:0]            left_r,
  player_mover_if.master        plot_bus,
  output logic [CW-1:0]         p_x,
  output logic [CW-1:0]         p_y,
  output logic                  busy
);

  localparam logic [CW:0] MAX_XV = (CW+1)'(MAX_X);
  localparam logic [CW:0] MAX_YV = (CW+1)'(MAX_Y);

  state_t        state, nstate;
  nb_t           nb;
  logic [2:0]    dir_q;
  logic          bomb_under;
  logic [2:0]    old_code;
  logic [CW-1:0] addr_x_q, addr_y_q;
  logic [CW-1:0] nb_x, nb_y;
  logic          nb_in;
  logic [CW:0]   xp1, yp1;
  logic          legal;
  logic          tmr_load, tmr_done;
  logic          cap_en;
  logic [2:0]    cap_val;

  ram_read_timer #(.LAT(RAM_LAT)) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .load   (tmr_load),
    .done   (tmr_done)
  );

  assign xp1 = {1'b0, p_x} + (CW+1)'(1);
  assign yp1 = {1'b0, p_y} + (CW+1)'(1);

  always_comb begin
    nb_x  = p_x;
    nb_y  = p_y;
    nb_in = 1'b0;
    case (nb)
      NB_LEFT:  begin nb_x = p_x - CW'(1);     nb_in = (p_x != '0);      end
      NB_RIGHT: begin nb_x = xp1[CW-1:0];      nb_in = (xp1 <= MAX_XV);  end
      NB_UP:    begin nb_y = yp1[CW-1:0];      nb_in = (yp1 <= MAX_YV);  end
      default:  begin nb_y = p_y - CW'(1);     nb_in = (p_y != '0);      end
    endcase
  end

  always_comb begin
    case (dir_q)
      DIR_UP:    legal = (up_r    == CELL_TILE);
      DIR_RIGHT: legal = (right_r == CELL_TILE);
      DIR_DOWN:  legal = (down_r  == CELL_TILE);
      DIR_LEFT:  legal = (left_r  == CELL_TILE);
      default:   legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= nstate;
  end

  // RAM address is combinational while driven so a read issued in RD_ADDR sees
  // exactly RAM_LAT cycles to RD_CAP; otherwise it holds the last driven value.
  always_comb begin
    nstate            = state;
    busy              = (state != S_IDLE);
    ram_x             = addr_x_q;
    ram_y             = addr_y_q;
    ram_wren          = 1'b0;
    ram_wdata         = '0;
    plot_bus.plot     = 1'b0;
    plot_bus.plot_x   = '0;
    plot_bus.plot_y   = '0;
    plot_bus.plot_val = '0;
    tmr_load          = 1'b0;
    cap_en            = 1'b0;
    cap_val           = ram_rdata;
    case (state)
      S_IDLE: if (ld) nstate = S_RD_ADDR;
      S_RD_ADDR: begin
        if (nb_in) begin
          ram_x    = nb_x;
          ram_y    = nb_y;
          tmr_load = 1'b1;
          nstate   = (RAM_LAT == 1) ? S_RD_CAP : S_RD_WAIT;
        end else begin
          cap_en  = 1'b1;
          cap_val = CELL_WALL;
          nstate  = (nb == NB_DOWN) ? S_DECIDE : S_RD_ADDR;
        end
      end
      S_RD_WAIT: if (tmr_done) nstate = S_RD_CAP;
      S_RD_CAP: begin
        cap_en = 1'b1;
        nstate = (nb == NB_DOWN) ? S_DECIDE : S_RD_ADDR;
      end
      S_DECIDE: nstate = legal ? S_WR_OLD : S_IDLE;
      S_WR_OLD: begin
        ram_wren  = 1'b1;
        ram_x     = p_x;
        ram_y     = p_y;
        ram_wdata = bomb_under ? CELL_BOMB : CELL_TILE;
        nstate    = S_PLOT_OLD;
      end
      S_PLOT_OLD: begin
        plot_bus.plot     = 1'b1;
        plot_bus.plot_x   = p_x;
        plot_bus.plot_y   = p_y;
        plot_bus.plot_val = old_code;
        if (plot_bus.plot_ready) nstate = S_MOVE;
      end
      S_MOVE: nstate = S_WR_NEW;
      S_WR_NEW: begin
        ram_wren  = 1'b1;
        ram_x     = p_x;
        ram_y     = p_y;
        ram_wdata = CELL_PLAYER;
        nstate    = S_PLOT_NEW;
      end
      S_PLOT_NEW: begin
        plot_bus.plot     = 1'b1;
        plot_bus.plot_x   = p_x;
        plot_bus.plot_y   = p_y;
        plot_bus.plot_val = CELL_PLAYER;
        if (plot_bus.plot_ready) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      nb         <= NB_LEFT;
      dir_q      <= '0;
      p_x        <= CW'(SPAWN_X);
      p_y        <= CW'(SPAWN_Y);
      up_r       <= '0;
      right_r    <= '0;
      down_r     <= '0;
      left_r     <= '0;
      bomb_under <= 1'b0;
      old_code   <= '0;
      addr_x_q   <= '0;
      addr_y_q   <= '0;
    end else begin
      addr_x_q <= ram_x;
      addr_y_q <= ram_y;
      if (state == S_IDLE && ld) begin
        dir_q <= dir;
        nb    <= NB_LEFT;
      end
      if (cap_en) begin
        case (nb)
          NB_LEFT:  left_r  <= cap_val;
          NB_RIGHT: right_r <= cap_val;
          NB_UP:    up_r    <= cap_val;
          default:  down_r  <= cap_val;
        endcase
        nb <= nb_t'(nb + 2'd1);
      end
      if (state == S_DECIDE && dir_q == DIR_PLANT) bomb_under <= 1'b1;
      if (state == S_WR_OLD) begin
        old_code   <= ram_wdata;
        bomb_under <= 1'b0;
      end
      if (state == S_MOVE) begin
        case (dir_q)
          DIR_UP:    p_y <= p_y + CW'(1);
          DIR_RIGHT: p_x <= p_x + CW'(1);
          DIR_DOWN:  p_y <= p_y - CW'(1);
          DIR_LEFT:  p_x <= p_x - CW'(1);
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover with an arena RAM model and write/plot scoreboards.
module tb_player_mover;
  import player_mover_pkg::*;

  localparam int unsigned CW      = 4;
  localparam int unsigned RAM_LAT = 2;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] v;
  } ev_t;

  logic          clk;
  logic          resetn;
  logic          ld;
  logic [2:0]    dir;
  logic [2:0]    ram_rdata;
  logic [CW-1:0] ram_x, ram_y;
  logic          ram_wren;
  logic [2:0]    ram_wdata;
  logic [2:0]    up_r, right_r, down_r, left_r;
  logic [CW-1:0] p_x, p_y;
  logic          busy;
  logic          pr;
  logic          init_req;

  player_mover_if #(.CW(CW)) pif ();
  assign pif.plot_ready = pr;

  player_mover #(
    .CW(CW), .MAX_X(11), .MAX_Y(9), .RAM_LAT(RAM_LAT), .SPAWN_X(1), .SPAWN_Y(1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ld        (ld),
    .dir       (dir),
    .ram_rdata (ram_rdata),
    .ram_x     (ram_x),
    .ram_y     (ram_y),
    .ram_wren  (ram_wren),
    .ram_wdata (ram_wdata),
    .up_r      (up_r),
    .right_r   (right_r),
    .down_r    (down_r),
    .left_r    (left_r),
    .plot_bus  (pif),
    .p_x       (p_x),
    .p_y       (p_y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arena RAM: synchronous read with RAM_LAT cycles of latency, write on ram_wren.
  logic [2:0] mem  [0:15][0:15];
  logic [2:0] pipe [0:RAM_LAT-1];
  assign ram_rdata = pipe[RAM_LAT-1];

  always @(posedge clk) begin
    pipe[0] <= mem[ram_x][ram_y];
    for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
    if (init_req) begin
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          mem[x][y] <= (x == 0 || x == 11 || y == 0 || y == 9) ? CELL_WALL : CELL_TILE;
      mem[1][1] <= CELL_PLAYER;
      mem[1][2] <= CELL_BLOCK;
      mem[4][0] <= CELL_TILE;
    end else if (ram_wren) begin
      mem[ram_x][ram_y] <= ram_wdata;
    end
  end

  int  checks = 0;
  int  failures = 0;
  int  nwr_obs, nwr_exp, npl_obs, npl_exp;
  int  cyc;
  int  n;
  ev_t wq[$];
  ev_t pq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_cmd();
    wq.delete();
    pq.delete();
    nwr_obs = 0; nwr_exp = 0; npl_obs = 0; npl_exp = 0;
  endtask

  task automatic expect_ev(input logic [3:0] x, input logic [3:0] y, input logic [2:0] v);
    wq.push_back('{x: x, y: y, v: v});
    pq.push_back('{x: x, y: y, v: v});
    nwr_exp++;
    npl_exp++;
  endtask

  task automatic monitor();
    ev_t e;
    if (ram_wren === 1'b1) begin
      nwr_obs++;
      if (wq.size() > 0) begin
        e = wq.pop_front();
        chk("wr_x", 32'(ram_x), 32'(e.x));
        chk("wr_y", 32'(ram_y), 32'(e.y));
        chk("wr_val", 32'(ram_wdata), 32'(e.v));
      end
    end
    if (pif.plot === 1'b1 && pr === 1'b1) begin
      npl_obs++;
      if (pq.size() > 0) begin
        e = pq.pop_front();
        chk("plot_x", 32'(pif.plot_x), 32'(e.x));
        chk("plot_y", 32'(pif.plot_y), 32'(e.y));
        chk("plot_val", 32'(pif.plot_val), 32'(e.v));
      end
    end
  endtask

  task automatic do_cmd(input logic [2:0] d, output int c);
    @(negedge clk);
    ld  = 1'b1;
    dir = d;
    @(negedge clk);
    ld  = 1'b0;
    dir = DIR_IDLE;
    c   = 0;
    while (busy === 1'b1 && c < 200) begin
      monitor();
      @(negedge clk);
      c++;
    end
  endtask

  task automatic end_cmd(input string tag);
    chk({tag, "_nwr"}, 32'(nwr_obs), 32'(nwr_exp));
    chk({tag, "_nplot"}, 32'(npl_obs), 32'(npl_exp));
  endtask

  initial begin
    resetn = 1'b0; ld = 1'b0; dir = DIR_IDLE; pr = 1'b1; init_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    init_req = 1'b0;

    // Reset state
    chk("rst_px", 32'(p_x), 1);
    chk("rst_py", 32'(p_y), 1);
    chk("rst_plot", 32'(pif.plot), 0);
    chk("rst_wren", 32'(ram_wren), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_nbr", {20'd0, up_r, right_r, down_r, left_r}, 0);
    resetn = 1'b1;

    // Idle scan at spawn
    begin_cmd();
    do_cmd(DIR_IDLE, cyc);
    chk("scan_lat", 32'(cyc), 13);
    chk("scan_left", 32'(left_r), CELL_WALL);
    chk("scan_right", 32'(right_r), CELL_TILE);
    chk("scan_up", 32'(up_r), CELL_BLOCK);
    chk("scan_down", 32'(down_r), CELL_WALL);
    end_cmd("scan");

    // Blocked move up
    begin_cmd();
    do_cmd(DIR_UP, cyc);
    chk("blk_lat", 32'(cyc), 13);
    chk("blk_up", 32'(up_r), CELL_BLOCK);
    chk("blk_p", {24'd0, p_x, p_y}, {24'd0, 4'd1, 4'd1});
    end_cmd("blk");

    // Legal move right
    begin_cmd();
    expect_ev(1, 1, CELL_TILE);
    expect_ev(2, 1, CELL_PLAYER);
    do_cmd(DIR_RIGHT, cyc);
    chk("mv_lat", 32'(cyc), 18);
    chk("mv_p", {24'd0, p_x, p_y}, {24'd0, 4'd2, 4'd1});
    end_cmd("mv");

    // Plant a bomb, then walk off it twice
    begin_cmd();
    do_cmd(DIR_PLANT, cyc);
    chk("plant_lat", 32'(cyc), 13);
    end_cmd("plant");
    begin_cmd();
    expect_ev(2, 1, CELL_BOMB);
    expect_ev(3, 1, CELL_PLAYER);
    do_cmd(DIR_RIGHT, cyc);
    chk("bomb_p", {24'd0, p_x, p_y}, {24'd0, 4'd3, 4'd1});
    end_cmd("bomb");
    begin_cmd();
    expect_ev(3, 1, CELL_TILE);
    expect_ev(4, 1, CELL_PLAYER);
    do_cmd(DIR_RIGHT, cyc);
    chk("clr_p", {24'd0, p_x, p_y}, {24'd0, 4'd4, 4'd1});
    end_cmd("clr");

    // Onto row 0, where the downward neighbour is off the arena
    begin_cmd();
    expect_ev(4, 1, CELL_TILE);
    expect_ev(4, 0, CELL_PLAYER);
    do_cmd(DIR_DOWN, cyc);
    chk("dn_lat", 32'(cyc), 18);
    chk("dn_p", {24'd0, p_x, p_y}, {24'd0, 4'd4, 4'd0});
    end_cmd("dn");
    begin_cmd();
    do_cmd(DIR_DOWN, cyc);
    chk("oob_lat", 32'(cyc), 11);
    chk("oob_down", 32'(down_r), CELL_WALL);
    chk("oob_up", 32'(up_r), CELL_TILE);
    chk("oob_left", 32'(left_r), CELL_WALL);
    chk("oob_p", {24'd0, p_x, p_y}, {24'd0, 4'd4, 4'd0});
    end_cmd("oob");

    // Plot stall, then reset mid-stall
    resetn = 1'b0; init_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    init_req = 1'b0; resetn = 1'b1;
    pr = 1'b0;
    begin_cmd();
    wq.push_back('{x: 4'd1, y: 4'd1, v: CELL_TILE});
    nwr_exp = 1;
    @(negedge clk);
    ld = 1'b1; dir = DIR_RIGHT;
    @(negedge clk);
    ld = 1'b0; dir = DIR_IDLE;
    n = 0;
    while (pif.plot !== 1'b1 && n < 100) begin
      monitor();
      @(negedge clk);
      n++;
    end
    chk("stall_plot", 32'(pif.plot), 1);
    for (int i = 0; i < 5; i++) begin
      monitor();
      chk("stall_hold", {20'd0, pif.plot, pif.plot_x, pif.plot_y, pif.plot_val},
          {20'd0, 1'b1, 4'd1, 4'd1, 3'(CELL_TILE)});
      chk("stall_busy", 32'(busy), 1);
      @(negedge clk);
    end
    chk("stall_nwr", 32'(nwr_obs), 32'(nwr_exp));
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_plot", 32'(pif.plot), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_wren", 32'(ram_wren), 0);
    chk("abort_p", {24'd0, p_x, p_y}, {24'd0, 4'd1, 4'd1});
    resetn = 1'b1;
    pr = 1'b1;
    @(negedge clk);
    chk("abort_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
